// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared traffic-light constants, phase helpers and scheduler states
package tl_pkg;

  // Phase indices of the four-approach light
  localparam logic [4:0] S0  = 5'd0;
  localparam logic [4:0] S1  = 5'd1;
  localparam logic [4:0] S2  = 5'd2;
  localparam logic [4:0] S3  = 5'd3;
  localparam logic [4:0] S4  = 5'd4;
  localparam logic [4:0] S5  = 5'd5;
  localparam logic [4:0] S6  = 5'd6;
  localparam logic [4:0] S7  = 5'd7;
  localparam logic [4:0] S8  = 5'd8;
  localparam logic [4:0] S9  = 5'd9;
  localparam logic [4:0] S10 = 5'd10;
  localparam logic [4:0] S11 = 5'd11;
  localparam logic [4:0] S12 = 5'd12;
  localparam logic [4:0] S13 = 5'd13;
  localparam logic [4:0] S14 = 5'd14;
  localparam logic [4:0] S15 = 5'd15;
  localparam logic [4:0] S16 = 5'd16;
  localparam logic [4:0] S17 = 5'd17;

  // Phases in which every approach shows red
  localparam logic [4:0] ALLRED_A = S0;
  localparam logic [4:0] ALLRED_B = S6;
  localparam logic [4:0] ALLRED_C = S14;

  // Lamp colour codes
  localparam logic [1:0] COL_G  = 2'd0;
  localparam logic [1:0] COL_Y  = 2'd1;
  localparam logic [1:0] COL_R  = 2'd2;
  localparam logic [1:0] COL_RY = 2'd3;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_t;

  // Out-of-range indices (18..31) are never all-red
  function automatic logic is_allred(input logic [4:0] p);
    return (p == ALLRED_A) || (p == ALLRED_B) || (p == ALLRED_C);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way combinational round-robin arbiter
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gidx
);

  logic [1:0] idx;
  logic       found;

  // Scan upward from ptr with wrap; the first requester found wins
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_ped_scheduler.sv
// rtl/tl_ped_scheduler.sv - pedestrian-call scheduler freezing the light in all-red phases
module tl_ped_scheduler
  import tl_pkg::*;
#(
  parameter int WALK_CYC  = 8,
  parameter int CLEAR_CYC = 4,
  parameter int CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] PHASE,
  input  logic [3:0] REQ,
  input  logic       HOLD,
  output logic       GO,
  output logic [3:0] WALK,
  output logic       FLASH,
  output logic [3:0] PEND,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  sched_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       phase_q;
  logic [3:0]       pend;
  logic [3:0]       gnt;
  logic [3:0]       gnt_q;
  logic [1:0]       ptr;
  logic [1:0]       gidx;
  logic             entry;
  logic             fire;
  logic             cnt_zero;

  // A fresh arrival in an all-red phase opens a service window
  assign entry    = is_allred(PHASE) && (PHASE != phase_q);
  assign fire     = (state == ST_IDLE) && entry && (|pend);
  assign cnt_zero = (cnt == '0);

  rr_arbiter4 u_arb (
    .req  (pend),
    .ptr  (ptr),
    .gnt  (gnt),
    .gidx (gidx)
  );

  // Previous phase, used to detect the first cycle of an all-red phase
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) phase_q <= '0;
    else      phase_q <= PHASE;
  end

  // Request latch; a new press of the crossing being granted survives the clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) pend <= '0;
    else      pend <= (pend & ~(fire ? gnt : 4'b0000)) | REQ;
  end

  // Round-robin pointer and the crossing served in the current window
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr   <= '0;
      gnt_q <= '0;
    end else if (fire) begin
      ptr   <= gidx + 2'd1;
      gnt_q <= gnt;
    end
  end

  // Scheduler state and interval counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: IDLE -> WALK on a window with pending calls, then timed WALK and CLEAR
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          state_n = ST_WALK;
          cnt_n   = WALK_LOAD;
        end
      end
      ST_WALK: begin
        if (cnt_zero) begin
          state_n = ST_CLEAR;
          cnt_n   = CLEAR_LOAD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ST_CLEAR: begin
        if (cnt_zero) state_n = ST_IDLE;
        else          cnt_n   = cnt - CNT_ONE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs: GO drops combinationally in the entry cycle so the light never leaves all-red
  always_comb begin
    GO    = ~HOLD & (state == ST_IDLE) & ~fire;
    WALK  = (state == ST_WALK) ? gnt_q : 4'b0000;
    FLASH = (state == ST_CLEAR);
    PEND  = pend;
    BUSY  = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_tl_ped_scheduler.sv
// tb/tb_tl_ped_scheduler.sv - self-checking bench for tl_ped_scheduler
module tb_tl_ped_scheduler;

  localparam int WALK_CYC  = 8;
  localparam int CLEAR_CYC = 4;
  localparam int CNT_W     = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] PHASE;
  logic [3:0] REQ;
  logic       HOLD;
  logic       GO;
  logic [3:0] WALK;
  logic       FLASH;
  logic [3:0] PEND;
  logic       BUSY;

  tl_ped_scheduler #(
    .WALK_CYC  (WALK_CYC),
    .CLEAR_CYC (CLEAR_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .PHASE (PHASE),
    .REQ   (REQ),
    .HOLD  (HOLD),
    .GO    (GO),
    .WALK  (WALK),
    .FLASH (FLASH),
    .PEND  (PEND),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: pending set, pointer, and elapsed time in the current window
  logic [3:0] m_pend;
  int         m_ptr;
  int         m_phase_q;
  int         m_g;
  int         m_el;

  typedef struct {
    logic [4:0] phase;
    logic [3:0] req;
    logic       hold;
    logic       go;
    logic [3:0] walk;
    logic       flash;
    logic [3:0] pend;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit allred(input int p);
    return (p == 0) || (p == 6) || (p == 14);
  endfunction

  function automatic bit m_fire();
    return (m_g < 0) && allred(int'(PHASE)) && (int'(PHASE) != m_phase_q) && (m_pend != 4'b0);
  endfunction

  task automatic model_reset();
    m_pend    = 4'b0;
    m_ptr     = 0;
    m_phase_q = 0;
    m_g       = -1;
    m_el      = 0;
  endtask

  task automatic model_check();
    logic [3:0] ew;
    ew = (m_g >= 0 && m_el < WALK_CYC) ? 4'(1 << m_g) : 4'b0;
    check("m_go",    GO,    32'(!HOLD && m_g < 0 && !m_fire()));
    check("m_walk",  WALK,  32'(ew));
    check("m_flash", FLASH, 32'(m_g >= 0 && m_el >= WALK_CYC));
    check("m_pend",  PEND,  32'(m_pend));
    check("m_busy",  BUSY,  32'(m_g >= 0));
  endtask

  // Advance the model across one rising edge using the inputs held before it
  task automatic model_step();
    bit f;
    bit found;
    int idx;
    if (!RST) begin
      model_reset();
    end else begin
      f = m_fire();
      if (m_g >= 0) begin
        m_el++;
        if (m_el == WALK_CYC + CLEAR_CYC) m_g = -1;
      end else if (f) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (!found && m_pend[idx]) begin
            found = 1;
            m_g = idx;
          end
        end
        m_el = 0;
        m_pend[m_g] = 1'b0;
        m_ptr = (m_g + 1) % 4;
      end
      m_pend    = m_pend | REQ;
      m_phase_q = int'(PHASE);
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    model_check();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_reset();
    cycle();
    cycle();
    RST = 1'b1;
  endtask

  task automatic add(input logic [4:0] ph, input logic [3:0] rq, input logic hd, input logic go,
                     input logic [3:0] wk, input logic fl, input logic [3:0] pd, input logic by);
    vec_t v;
    v.phase = ph; v.req = rq; v.hold = hd; v.go = go;
    v.walk = wk; v.flash = fl; v.pend = pd; v.busy = by;
    tbl.push_back(v);
  endtask

  // Approach all-red phase p from its predecessor and serve one window
  task automatic serve(input logic [4:0] p, input logic [3:0] exp_walk, input logic [3:0] mid_req);
    PHASE = (p == 5'd0) ? 5'd17 : p - 5'd1;
    cycle();
    PHASE = p;
    #1 check("entry_go", GO, 0);
    cycle();
    #1 check("serve_walk", WALK, 32'(exp_walk));
    for (int i = 0; i < WALK_CYC + CLEAR_CYC; i++) begin
      REQ = (i == 2) ? mid_req : 4'b0;
      cycle();
    end
    REQ = 4'b0;
    #1 check("serve_go_back", GO, 1);
    cycle();
  endtask

  initial begin
    int wcnt;
    RST   = 1'b0;
    PHASE = 5'd0;
    REQ   = 4'b0;
    HOLD  = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("rst_go",    GO,    1);
      check("rst_walk",  WALK,  0);
      check("rst_flash", FLASH, 0);
      check("rst_pend",  PEND,  0);
      check("rst_busy",  BUSY,  0);
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;

    // Pass-through of phases 0..6 with no calls, then one served window for crossing 2
    for (int p = 0; p <= 6; p++) add(5'(p), 4'b0, 0, 1, 4'b0, 0, 4'b0, 0);
    add(5'd3, 4'b0100, 0, 1, 4'b0, 0, 4'b0, 0);
    add(5'd3, 4'b0000, 0, 1, 4'b0, 0, 4'b0100, 0);
    add(5'd6, 4'b0000, 0, 0, 4'b0, 0, 4'b0100, 0);
    for (int i = 0; i < WALK_CYC; i++)  add(5'd6, 4'b0, 0, 0, 4'b0100, 0, 4'b0, 1);
    for (int i = 0; i < CLEAR_CYC; i++) add(5'd6, 4'b0, 0, 0, 4'b0, 1, 4'b0, 1);
    add(5'd6, 4'b0, 0, 1, 4'b0, 0, 4'b0, 0);
    add(5'd7, 4'b0, 0, 1, 4'b0, 0, 4'b0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      PHASE = tbl[i].phase;
      REQ   = tbl[i].req;
      HOLD  = tbl[i].hold;
      @(negedge CLK);
      check($sformatf("tbl%0d_go", i),    GO,    32'(tbl[i].go));
      check($sformatf("tbl%0d_walk", i),  WALK,  32'(tbl[i].walk));
      check($sformatf("tbl%0d_flash", i), FLASH, 32'(tbl[i].flash));
      check($sformatf("tbl%0d_pend", i),  PEND,  32'(tbl[i].pend));
      check($sformatf("tbl%0d_busy", i),  BUSY,  32'(tbl[i].busy));
      model_step();
      @(posedge CLK);
      #1;
    end
    REQ = 4'b0;

    // All four crossings at once: served in order over successive windows, pointer wraps
    do_reset();
    REQ = 4'b1111;
    cycle();
    REQ = 4'b0;
    serve(5'd6,  4'b0001, 4'b0);
    serve(5'd14, 4'b0010, 4'b0);
    serve(5'd0,  4'b0100, 4'b0);
    serve(5'd6,  4'b1000, 4'b0);
    REQ = 4'b1010;
    cycle();
    REQ = 4'b0;
    serve(5'd14, 4'b0010, 4'b0);
    #1 check("wrap_pend", PEND, 32'(4'b1000));

    // Re-request during own WALK is kept for the next window
    do_reset();
    REQ = 4'b0010;
    cycle();
    REQ = 4'b0;
    serve(5'd6, 4'b0010, 4'b0010);
    #1 check("rereq_pend", PEND, 32'(4'b0010));
    serve(5'd14, 4'b0010, 4'b0);
    #1 check("rereq_done", PEND, 0);

    // Request on the granting edge: set wins over clear
    REQ = 4'b0001;
    cycle();
    REQ = 4'b0;
    PHASE = 5'd5;
    cycle();
    PHASE = 5'd6;
    REQ = 4'b0001;
    cycle();
    REQ = 4'b0;
    #1 check("setwin_walk", WALK, 32'(4'b0001));
    check("setwin_pend", PEND, 32'(4'b0001));
    for (int i = 0; i < WALK_CYC + CLEAR_CYC; i++) cycle();
    serve(5'd14, 4'b0001, 4'b0);

    // Asynchronous reset in the third WALK cycle
    REQ = 4'b1001;
    cycle();
    REQ = 4'b0;
    PHASE = 5'd5;
    cycle();
    PHASE = 5'd6;
    cycle();
    cycle();
    cycle();
    #1 check("pre_rst_busy", BUSY, 1);
    RST = 1'b0;
    model_reset();
    #1;
    check("arst_walk",  WALK,  0);
    check("arst_flash", FLASH, 0);
    check("arst_busy",  BUSY,  0);
    check("arst_pend",  PEND,  0);
    check("arst_go",    GO,    1);
    cycle();
    cycle();
    RST = 1'b1;
    PHASE = 5'd5;
    cycle();
    PHASE = 5'd6;
    #1 check("post_rst_entry_go", GO, 1);
    cycle();
    cycle();

    // Maintenance hold with no calls
    PHASE = 5'd2;
    HOLD = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 check("hold_go", GO, 0);
      cycle();
    end
    HOLD = 1'b0;
    #1 check("hold_release_go", GO, 1);
    cycle();

    // Hold asserted through a WALK does not stretch it
    REQ = 4'b0100;
    cycle();
    REQ = 4'b0;
    PHASE = 5'd5;
    cycle();
    PHASE = 5'd6;
    HOLD = 1'b1;
    cycle();
    wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (WALK != 4'b0) wcnt++;
      cycle();
    end
    check("hold_walk_len", wcnt, WALK_CYC);
    HOLD = 1'b0;
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)      PHASE = 5'($urandom_range(0, 31));
      else if ($urandom_range(0, 3) == 0)  PHASE = (PHASE >= 5'd17) ? 5'd0 : PHASE + 5'd1;
      REQ  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      HOLD = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
